// File: rtl/arith_pkg.sv
// Shared arithmetic-library types, constants and elaboration helpers.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Ceiling log2 for sizing counters at elaboration time.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fa1.sv
// Single-bit full-adder cell.
module fa1 (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple chain of fa1 cells.
module serial_addsub
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STEPS = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

   if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : gen_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_e           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CNT_W-1:0] count;

   // c[i] is the carry into cell i of this step; c[DIGIT] leaves the chain.
   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] s_dig;

   assign c[0] = carry;

   for (genvar i = 0; i < DIGIT; i++) begin : gen_chain
      fa1 u_fa1 (
         .s    (s_dig[i]),
         .cout (c[i+1]),
         .a    (a_sh[i]),
         .b    (b_sh[i]),
         .cin  (c[i])
      );
   end

   // Control FSM and datapath registers; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
                  a_sh  <= a;
                  b_sh  <= (sub == SUB) ? ~b : b;
                  carry <= sub;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               sum   <= WIDTH'({s_dig, sum} >> DIGIT);
               carry <= c[DIGIT];
               count <= count + 1'b1;
               if (count == CNT_W'(STEPS - 1)) begin
                  // Final digit holds the MSB, so c[DIGIT-1] is the carry into bit WIDTH-1.
                  cout  <= c[DIGIT];
                  ovf   <= c[DIGIT-1] ^ c[DIGIT];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub in three configurations: 8/1, 8/4 and 16/16.
module tb_serial_addsub;
   import arith_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start_v [3];
   logic        sub_v   [3];
   logic [15:0] a_v     [3];
   logic [15:0] b_v     [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        cout_v  [3];
   logic        ovf_v   [3];
   logic [15:0] sum_v   [3];
   logic [7:0]  sum8_0;
   logic [7:0]  sum8_1;
   logic [15:0] sum16_2;

   int checks = 0;
   int errors = 0;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
      .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
      .sum(sum8_0), .cout(cout_v[0]), .ovf(ovf_v[0])
   );

   serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
      .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]),
      .sum(sum8_1), .cout(cout_v[1]), .ovf(ovf_v[1])
   );

   serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]),
      .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .sum(sum16_2), .cout(cout_v[2]), .ovf(ovf_v[2])
   );

   assign sum_v[0] = {8'h00, sum8_0};
   assign sum_v[1] = {8'h00, sum8_1};
   assign sum_v[2] = sum16_2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation from idle: checks latency, result flags and the one-cycle done pulse.
   task automatic op(input int d, input logic [15:0] av, input logic [15:0] bv,
                     input logic sv, input logic [15:0] es, input logic ec,
                     input logic eo, input int steps, input string tag);
      int n;
      a_v[d]     = av;
      b_v[d]     = bv;
      sub_v[d]   = sv;
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      check({tag, " busy"}, 32'(busy_v[d]), 32'd1);
      n = 0;
      while (done_v[d] !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(steps));
      check({tag, " sum"}, 32'(sum_v[d]), 32'(es));
      check({tag, " cout"}, 32'(cout_v[d]), 32'(ec));
      check({tag, " ovf"}, 32'(ovf_v[d]), 32'(eo));
      check({tag, " busy_done"}, 32'(busy_v[d]), 32'd0);
      tick();
      check({tag, " pulse"}, 32'(done_v[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      logic [15:0] got;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         sub_v[i]   = ADD;
         a_v[i]     = '0;
         b_v[i]     = '0;
      end
      tick();
      tick();
      check("rst busy", 32'(busy_v[0]), 32'd0);
      check("rst done", 32'(done_v[0]), 32'd0);
      check("rst sum", 32'(sum_v[0]), 32'd0);
      check("rst cout", 32'(cout_v[0]), 32'd0);
      check("rst ovf", 32'(ovf_v[0]), 32'd0);
      check("rst sum d4", 32'(sum_v[1]), 32'd0);
      rst = 1'b0;
      tick();

      // WIDTH=8, DIGIT=1
      op(0, 16'd100, 16'd27,  ADD, 16'h007F, 1'b0, 1'b0, 8, "add100_27");
      op(0, 16'd127, 16'd1,   ADD, 16'h0080, 1'b0, 1'b1, 8, "add127_1");
      op(0, 16'd200, 16'd100, ADD, 16'h002C, 1'b1, 1'b0, 8, "add200_100");
      op(0, 16'd7,   16'd5,   SUB, 16'h0002, 1'b1, 1'b0, 8, "sub7_5");
      op(0, 16'd5,   16'd7,   SUB, 16'h00FE, 1'b0, 1'b0, 8, "sub5_7");
      op(0, 16'h80,  16'd1,   SUB, 16'h007F, 1'b1, 1'b1, 8, "sub80_1");

      // Request during RUN is dropped, not queued.
      a_v[0] = 16'd1; b_v[0] = 16'd1; sub_v[0] = ADD; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      a_v[0] = 16'd50; b_v[0] = 16'd50; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      ndone = 0;
      got = '0;
      repeat (16) begin
         tick();
         if (done_v[0] === 1'b1) begin
            ndone++;
            got = sum_v[0];
         end
      end
      check("ignore ndone", 32'(ndone), 32'd1);
      check("ignore sum", 32'(got), 32'd2);

      // Reset mid-RUN aborts without a done.
      a_v[0] = 16'd9; b_v[0] = 16'd9; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("abort busy", 32'(busy_v[0]), 32'd0);
      check("abort sum", 32'(sum_v[0]), 32'd0);
      check("abort done", 32'(done_v[0]), 32'd0);
      rst = 1'b0;
      ndone = 0;
      repeat (12) begin
         tick();
         if (done_v[0] === 1'b1) ndone++;
      end
      check("abort ndone", 32'(ndone), 32'd0);
      op(0, 16'd3, 16'd4, ADD, 16'h0007, 1'b0, 1'b0, 8, "after_abort");

      // WIDTH=8, DIGIT=4
      op(1, 16'hF0, 16'h0F, ADD, 16'h00FF, 1'b0, 1'b0, 2, "d4_addF0_0F");
      op(1, 16'h80, 16'h01, SUB, 16'h007F, 1'b1, 1'b1, 2, "d4_sub80_1");

      // Held start: one result every third cycle, no idle bubble.
      a_v[1] = 16'h12; b_v[1] = 16'h34; sub_v[1] = ADD; start_v[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("b2b done k%0d", k), 32'(done_v[1]), 32'((k % 3) == 0));
         check($sformatf("b2b busy k%0d", k), 32'(busy_v[1]), 32'((k % 3) != 0));
         if (k == 6) check("b2b sum", 32'(sum_v[1]), 32'h46);
      end
      start_v[1] = 1'b0;
      tick();

      // WIDTH=16, DIGIT=16: single-step operation
      op(2, 16'h7FFF, 16'h0001, ADD, 16'h8000, 1'b0, 1'b1, 1, "d16_ovf");
      op(2, 16'h1234, 16'h1234, SUB, 16'h0000, 1'b1, 1'b0, 1, "d16_zero");
      op(2, 16'hFFFF, 16'hFFFF, ADD, 16'hFFFE, 1'b1, 1'b0, 1, "d16_carry");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
